// File: rtl/spi_wr.sv
// spi_wr: DS1302-style serial write engine. On a rising edge of wr_start_flag
// (while idle) it captures {reg_data, control_data}, raises ce, shifts the 16 bits
// out LSB first on io_out/sclk, then holds ce, drops it for a recovery gap and
// pulses done.
// Ports: sys_clk (clock), rst (sync, active-low), wr_start_flag, control_data[7:0],
//        reg_data[7:0] in; ce, sclk, io_out, io_oe, busy, done out (all registered).
// Macro SPI_WR_FORCE_WRITE_EN: when defined, bit 0 of the command byte is sent as 0.
module spi_wr #(
  parameter int CE_SETUP = 4,
  parameter int CE_HOLD  = 2,
  parameter int CE_IDLE  = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       wr_start_flag,
  input  logic [7:0] control_data,
  input  logic [7:0] reg_data,
  output logic       ce,
  output logic       sclk,
  output logic       io_out,
  output logic       io_oe,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER, DONE} state_t;
  state_t      state_q, state_d;
  logic        start_dly_q;
  logic [15:0] shreg_q, shreg_d, cnt_q, cnt_d;
  logic [7:0]  cmd;
  logic        start;
  logic        ce_q, ce_d, sclk_q, sclk_d, io_out_q, io_out_d;
  logic        io_oe_q, io_oe_d, busy_q, busy_d, done_q, done_d;
`ifdef SPI_WR_FORCE_WRITE_EN
  assign cmd = {control_data[7:1], 1'b0};
`else
  assign cmd = control_data;
`endif
  assign start = wr_start_flag && !start_dly_q && state_q == IDLE;
  // cnt_q counts wait cycles in SETUP/HOLD/RECOVER; in SHIFT bit 0 is the sclk
  // phase and the upper bits the bit index, shifting after each high phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          shreg_d = {reg_data, cmd};
        end
      end
      SETUP:
        if (cnt_q == 16'(CE_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      SHIFT: begin
        if (cnt_q[0]) shreg_d = shreg_q >> 1;
        if (cnt_q == 16'd31) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD:
        if (cnt_q == 16'(CE_HOLD - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      RECOVER:
        if (cnt_q == 16'(CE_IDLE - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // Outputs are registered from the current state, so pins lag the state by one cycle.
  always_comb begin
    ce_d     = state_q inside {SETUP, SHIFT, HOLD};
    sclk_d   = state_q == SHIFT && cnt_q[0];
    io_out_d = state_q == SHIFT && shreg_q[0];
    io_oe_d  = state_q == SHIFT;
    busy_d   = state_q inside {SETUP, SHIFT, HOLD, RECOVER};
    done_d   = state_q == DONE;
  end
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      sclk_q      <= 1'b0;
      io_out_q    <= 1'b0;
      io_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= wr_start_flag;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      sclk_q      <= sclk_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign ce     = ce_q;
  assign sclk   = sclk_q;
  assign io_out = io_out_q;
  assign io_oe  = io_oe_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_spi_wr.sv
// tb_spi_wr: directed and random transactions checked cycle by cycle against a
// timing model built from the start edge T.
module tb_spi_wr;
  localparam int S   = 4;
  localparam int H   = 2;
  localparam int I   = 4;
  localparam int SH0 = S + 1;
  localparam int SH1 = S + 32;
  localparam int CE1 = S + 32 + H;
  localparam int BZ1 = CE1 + I;
  localparam int DK  = BZ1 + 1;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_start_flag = 1'b0;
  logic [7:0] control_data = '0;
  logic [7:0] reg_data = '0;
  logic       ce, sclk, io_out, io_oe, busy, done;
  int         n_cmp = 0;
  int         n_err = 0;
  spi_wr #(.CE_SETUP(S), .CE_HOLD(H), .CE_IDLE(I)) dut (
    .sys_clk(sys_clk), .rst(rst), .wr_start_flag(wr_start_flag),
    .control_data(control_data), .reg_data(reg_data),
    .ce(ce), .sclk(sclk), .io_out(io_out), .io_oe(io_oe), .busy(busy), .done(done)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] word(input logic [7:0] c, input logic [7:0] r);
`ifdef SPI_WR_FORCE_WRITE_EN
    c[0] = 1'b0;
`endif
    return {r, c};
  endfunction
  // Expected {ce,sclk,io_out,io_oe,busy,done} in the cycle after edge T+k.
  function automatic logic [5:0] model(input int k, input logic [15:0] w, input int abort_k);
    logic oe;
    if (abort_k >= 0 && k >= abort_k) return 6'b0;
    oe = k >= SH0 && k <= SH1;
    return {k >= 1 && k <= CE1, oe && ((k - SH0) % 2 == 1),
            oe ? w[4'((k - SH0) / 2)] : 1'b0, oe, k >= 1 && k <= BZ1, k == DK};
  endfunction
  // kind: 1 plain, 3 second start at T+10, 4 data change at T+5, 5 reset at T+20,
  // 6 flag held n cycles, 7 flag held across reset release.
  task automatic run(input string name, input logic [7:0] c, input logic [7:0] r,
                     input int kind, input int n);
    logic [15:0] w, bits;
    int rises, ce_n, dn, abort_k;
    logic prev;
    w = word(c, r); bits = '0; rises = 0; ce_n = 0; dn = 0; prev = 1'b0;
    abort_k = (kind == 5) ? 20 : -1;
    #1;
    control_data = c; reg_data = r; wr_start_flag = 1'b1;
    if (kind == 7) begin
      rst = 1'b0;
      @(posedge sys_clk);
      #1 rst = 1'b1;
    end
    @(posedge sys_clk);
    for (int k = 0; k < n; k++) begin
      #1;
      if (kind != 6 && k == 2) wr_start_flag = 1'b0;
      if (kind == 3 && k == 9) begin wr_start_flag = 1'b1; control_data = ~c; reg_data = ~r; end
      if (kind == 3 && k == 12) wr_start_flag = 1'b0;
      if (kind == 4 && k == 4) begin control_data = ~c; reg_data = ~r; end
      if (kind == 5 && k == 19) rst = 1'b0;
      if (kind == 5 && k == 20) rst = 1'b1;
      if (kind == 6 && k == n - 1) wr_start_flag = 1'b0;
      @(negedge sys_clk);
      check($sformatf("%s k=%0d outs", name, k), {26'd0, ce, sclk, io_out, io_oe, busy, done},
            {26'd0, model(k, w, abort_k)});
      if (sclk && !prev) begin
        if (rises < 16) bits[4'(rises)] = io_out;
        rises++;
      end
      prev = sclk;
      ce_n += int'(ce);
      dn += int'(done);
      @(posedge sys_clk);
    end
    if (abort_k < 0) begin
      check({name, " sclk_rises"}, rises, 16);
      check({name, " bitstream"}, {16'd0, bits}, {16'd0, w});
      check({name, " ce_cycles"}, ce_n, CE1);
    end
    check({name, " done_pulses"}, dn, (abort_k < 0) ? 1 : 0);
  endtask
  initial begin
    @(posedge sys_clk);
    #1 rst = 1'b1;
    @(negedge sys_clk);
    check("reset outs", {26'd0, ce, sclk, io_out, io_oe, busy, done}, 32'd0);
    run("s1", 8'hF1, 8'h43, 1, 46);
    run("s3", 8'hA5, 8'h3C, 3, 46);
    run("s4", 8'h5A, 8'hC3, 4, 46);
    run("s5", 8'h81, 8'h7E, 5, 46);
    run("s5b", 8'h81, 8'h7E, 1, 46);
    run("s6", 8'h96, 8'h69, 6, 100);
    run("s7", 8'h0F, 8'hF0, 7, 46);
    for (int i = 0; i < 4; i++)
      run($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1, 46);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_wr.md
SPI_WR -- requirements
Module: spi_wr

Interface
REQ-001 Parameter CE_SETUP, default 4, sys_clk cycles ce is held high before the first sclk edge (min 1).
REQ-002 Parameter CE_HOLD, default 2, sys_clk cycles ce stays high after the last sclk high phase (min 1).
REQ-003 Parameter CE_IDLE, default 4, sys_clk cycles ce stays low before done (min 1).
REQ-004 sys_clk  input  1  system clock, nominal 1 MHz; single clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 wr_start_flag  input  1  write request; rising edge starts one transaction.
REQ-007 control_data  input  8  DS1302 command byte (address/command).
REQ-008 reg_data  input  8  DS1302 data byte to write.
REQ-009 ce  output  1  DS1302 chip enable (RST pin), active-high.
REQ-010 sclk  output  1  serial clock to DS1302.
REQ-011 io_out  output  1  serial data driven toward DS1302 I/O pin.
REQ-012 io_oe  output  1  io_out drive enable; the tri-state buffer is external to this block.
REQ-013 busy  output  1  high while a transaction is in progress.
REQ-014 done  output  1  one-cycle pulse at transaction completion.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD, RECOVER and DONE; every output is registered.
- Start detection: start_d <= wr_start_flag each cycle; a start occurs at edge T when wr_start_flag=1, start_d=0 and state=IDLE.
- Start events in any state other than IDLE are ignored, with no queuing.
REQ-016 At edge T the block SHALL capture {reg_data, control_data} into a 16-bit shift register; input changes after T SHALL have no effect on the transaction.
REQ-017 SETUP SHALL occupy cycles T+1..T+CE_SETUP.
- ce=1, busy=1, sclk=0, io_oe=0.
REQ-018 SHIFT SHALL transmit 16 bits, LSB first: control_data[0..7], then reg_data[0..7].
- Each bit takes 2 cycles: a low phase (sclk=0, io_out=bit) followed by a high phase (sclk=1, io_out unchanged).
- io_out changes only while sclk=0.
- io_oe=1 for all 32 SHIFT cycles.
REQ-019 HOLD SHALL take CE_HOLD cycles with ce=1, sclk=0, io_oe=0, io_out=0.
REQ-020 RECOVER SHALL take CE_IDLE cycles with ce=0 and busy=1.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then the FSM SHALL return to IDLE.
REQ-022 Timing with defaults: ce rises after T+1; first sclk rise after T+6; last sclk fall after T+37; ce falls after T+39; done=1 in cycle T+43; the next start is accepted from T+44.
REQ-023 In IDLE the outputs SHALL be ce=0, sclk=0, io_out=0, io_oe=0, busy=0, done=0.
REQ-024 If wr_start_flag is held high, only one transaction SHALL occur; a new start requires a low-to-high transition.

Reset
REQ-025 While rst=0 at a sys_clk edge, the block SHALL:
- enter IDLE;
- clear start_d, the shift register and the bit/phase/wait counters;
- drive all outputs to their IDLE values.
REQ-026 Reset mid-transaction SHALL abort at once: ce=0 from the next edge, no done pulse.
REQ-027 A wr_start_flag held high across reset release SHALL start a transaction, because start_d resets to 0.

Configuration
REQ-028 Macro SPI_WR_FORCE_WRITE_EN.
- Defined: bit 0 of the transmitted command byte is forced to 0 (DS1302 write), whatever control_data[0] is.
- Undefined: control_data is transmitted unmodified.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Scenario 1 (macro undefined): rst low 1 cycle then high; control_data=0xF1, reg_data=0x43; wr_start_flag high 3 cycles.
  - io_out sampled at the 16 sclk rises = 1,0,0,0,1,1,1,1, 1,1,0,0,0,0,1,0.
  - Exactly 16 sclk pulses; ce high 4+32+2=38 cycles; one done pulse at T+43.
- Scenario 2 (macro defined): same stimulus as scenario 1 -> the first bit is 0 and the remaining 15 bits are unchanged.
- Scenario 3: second wr_start_flag rising edge at T+10 with different data -> ignored; the bit stream matches the first captured values; a single done pulse.
- Scenario 4: control_data/reg_data changed at T+5 -> the transmitted stream still equals the values captured at T.
- Scenario 5: rst=0 at T+20 -> ce, sclk, io_oe and busy are 0 from the next edge; no done pulse; a new start after release completes normally.
- Scenario 6: wr_start_flag held high for 100 cycles -> exactly one transaction and one done pulse.
